// File: rtl/vga_capture.sv
// vga_capture: samples a VGA pixel stream, packs active pixels to RGB555 and buffers them into SRAM writes
module vga_capture #(
   parameter logic [31:0] BASEADDRESS = 32'h4000_1000,
   parameter logic [19:0] FB_BASE = 20'h00000,
   parameter int MAX_PIXELS = 307200,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        ACLK,
   input  logic        RESET,
   input  logic        PIX_EN,
   input  logic        VGA_HS,
   input  logic        VGA_VS,
   input  logic        VGA_BLANK_N,
   input  logic [7:0]  RED,
   input  logic [7:0]  GREEN,
   input  logic [7:0]  BLUE,
   output logic [19:0] MEM_ADDR,
   output logic [15:0] MEM_DATA,
   output logic        MEM_WR,
   input  logic        MEM_READY,
   input  logic [31:0] ADDR,
   input  logic [31:0] DATA_I,
   input  logic        WRSTB,
   output logic [31:0] DATA_O,
   output logic        IRQ
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
   localparam logic [19:0] MAXP = 20'(MAX_PIXELS);
   typedef enum logic [2:0] {IDLE, WAIT_VS, CAPTURE, DRAIN, DONE} state_t;
   state_t state;
   logic [1:0] ctrl;
   logic done, ovf, clip;
   logic [10:0] hcount, line_cnt;
   logic [9:0] vcount, vrun;
   logic [19:0] idx;
   logic s_v, s_vs, s_vs_p, s_bl;
   logic [15:0] s_px;
   logic p_v;
   logic [19:0] p_addr;
   logic [15:0] p_data;
   logic [35:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0] cnt;
   logic ctrl_wr, stat_wr, vs_rise, pop, push_ok, busy;
   logic [31:0] status;
   logic unused_ok;
   assign unused_ok = &{1'b0, VGA_HS, DATA_I[31:4]};
   assign ctrl_wr = WRSTB && ADDR == BASEADDRESS;
   assign stat_wr = WRSTB && ADDR == BASEADDRESS + 32'd4;
   assign vs_rise = s_v && s_vs && !s_vs_p;
   assign pop = MEM_WR && MEM_READY;
   assign push_ok = p_v && (cnt != FULL || pop);
   assign busy = state == WAIT_VS || state == CAPTURE || state == DRAIN;
   assign status = {24'd0, 4'(cnt), clip, ovf, done, busy};
   assign MEM_WR = cnt != '0;
   assign {MEM_ADDR, MEM_DATA} = MEM_WR ? mem[rp] : '0;
   assign IRQ = done;
   always_comb
      DATA_O = ADDR == BASEADDRESS ? {30'd0, ctrl} :
               ADDR == BASEADDRESS + 32'd4 ? status :
               ADDR == BASEADDRESS + 32'd8 ? {21'd0, hcount} :
               ADDR == BASEADDRESS + 32'd12 ? {22'd0, vcount} : '0;
   always_ff @(posedge ACLK)
      if (push_ok) mem[wp] <= {p_addr, p_data};
   always_ff @(posedge ACLK) begin
      if (RESET) begin
         state <= IDLE;
         ctrl <= '0;
         {done, ovf, clip} <= '0;
         hcount <= '0;
         vcount <= '0;
         line_cnt <= '0;
         vrun <= '0;
         idx <= '0;
         s_v <= 1'b0;
         s_vs <= 1'b1;
         s_vs_p <= 1'b1;
         s_bl <= 1'b0;
         s_px <= '0;
         p_v <= 1'b0;
         p_addr <= '0;
         p_data <= '0;
         wp <= '0;
         rp <= '0;
         cnt <= '0;
      end else begin
         s_v <= PIX_EN;
         if (PIX_EN) begin
            s_vs <= VGA_VS;
            s_vs_p <= s_vs;
            s_bl <= VGA_BLANK_N;
            s_px <= {1'b0, BLUE[7:3], GREEN[7:3], RED[7:3]};
         end
         if (stat_wr) begin
            if (DATA_I[1]) done <= 1'b0;
            if (DATA_I[2]) ovf <= 1'b0;
            if (DATA_I[3]) clip <= 1'b0;
         end
         if (push_ok) wp <= wp + 1'b1;
         else if (p_v) ovf <= 1'b1;
         if (pop) rp <= rp + 1'b1;
         cnt <= cnt + (AW+1)'(push_ok) - (AW+1)'(pop);
         p_v <= 1'b0;
         case (state)
            WAIT_VS: if (vs_rise) begin
               idx <= '0;
               line_cnt <= '0;
               vrun <= '0;
               state <= CAPTURE;
            end
            CAPTURE: if (vs_rise) begin
               vcount <= vrun;
               state <= DRAIN;
            end else if (s_v && s_bl) begin
               line_cnt <= &line_cnt ? line_cnt : line_cnt + 1'b1;
               if (idx < MAXP) begin
                  p_v <= 1'b1;
                  p_addr <= FB_BASE + idx;
                  p_data <= s_px;
                  idx <= idx + 1'b1;
               end else clip <= 1'b1;
            end else if (s_v) begin
               // a nonzero count can only follow active samples, so this is the blank falling edge
               if (line_cnt != '0) begin
                  hcount <= line_cnt;
                  vrun <= &vrun ? vrun : vrun + 1'b1;
               end
               line_cnt <= '0;
            end
            DRAIN: if (cnt == '0 && !p_v) begin
               done <= 1'b1;
               state <= ctrl[1] ? WAIT_VS : DONE;
            end
            default: ;
         endcase
         if (ctrl_wr) begin
            ctrl <= DATA_I[1:0];
            state <= DATA_I[0] ? WAIT_VS : IDLE;
            wp <= '0;
            rp <= '0;
            cnt <= '0;
            p_v <= 1'b0;
            if (DATA_I[0]) {done, ovf, clip} <= '0;
         end
      end
   end
endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: randomized frames checked against a pixel-list reference model
module tb_vga_capture;
   localparam logic [31:0] BASE = 32'h4000_1000;
   localparam logic [19:0] FB = 20'h00000;
   localparam logic [19:0] FB_C = 20'h00100;
   logic ACLK = 0, RESET = 1, PIX_EN = 0, VGA_HS = 1, VGA_VS = 1, VGA_BLANK_N = 0;
   logic [7:0] RED = 0, GREEN = 0, BLUE = 0;
   logic MEM_READY = 1, WRSTB = 0;
   logic [31:0] ADDR = BASE + 4, DATA_I = 0;
   logic [19:0] mem_addr, mem_addr_c;
   logic [15:0] mem_data, mem_data_c;
   logic mem_wr, mem_wr_c, irq, irq_c;
   logic [31:0] data_o, data_o_c;
   int vectors = 0, miscompares = 0;
   logic [35:0] wq[$], wq_c[$], exp[$], exp_c[$];
   logic [23:0] px[32];

   always #5 ACLK = ~ACLK;

   vga_capture dut (.ACLK(ACLK), .RESET(RESET), .PIX_EN(PIX_EN), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
      .VGA_BLANK_N(VGA_BLANK_N), .RED(RED), .GREEN(GREEN), .BLUE(BLUE), .MEM_ADDR(mem_addr),
      .MEM_DATA(mem_data), .MEM_WR(mem_wr), .MEM_READY(MEM_READY), .ADDR(ADDR), .DATA_I(DATA_I),
      .WRSTB(WRSTB), .DATA_O(data_o), .IRQ(irq));
   vga_capture #(.FB_BASE(FB_C), .MAX_PIXELS(10)) dut_c (.ACLK(ACLK), .RESET(RESET), .PIX_EN(PIX_EN),
      .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N), .RED(RED), .GREEN(GREEN), .BLUE(BLUE),
      .MEM_ADDR(mem_addr_c), .MEM_DATA(mem_data_c), .MEM_WR(mem_wr_c), .MEM_READY(MEM_READY), .ADDR(ADDR),
      .DATA_I(DATA_I), .WRSTB(WRSTB), .DATA_O(data_o_c), .IRQ(irq_c));

   always @(negedge ACLK) begin
      if (mem_wr && MEM_READY) wq.push_back({mem_addr, mem_data});
      if (mem_wr_c && MEM_READY) wq_c.push_back({mem_addr_c, mem_data_c});
   end

   function automatic logic [15:0] pack(input logic [23:0] p);
      return {1'b0, p[7:3], p[15:11], p[23:19]};
   endfunction

   task automatic tick;
      @(posedge ACLK);
      #1;
   endtask

   task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
      ADDR = a;
      DATA_I = d;
      WRSTB = 1;
      tick;
      WRSTB = 0;
      ADDR = BASE + 4;
      #1;
   endtask

   task automatic cpu_read(input logic [31:0] a, output logic [31:0] d, output logic [31:0] dc);
      ADDR = a;
      #1;
      d = data_o;
      dc = data_o_c;
      ADDR = BASE + 4;
      #1;
   endtask

   task automatic sample(input logic vs, input logic hs, input logic bl, input logic [23:0] rgb, input bit gaps);
      if (gaps) repeat ($urandom_range(0, 1)) tick;
      VGA_VS = vs;
      VGA_HS = hs;
      VGA_BLANK_N = bl;
      {RED, GREEN, BLUE} = rgb;
      PIX_EN = 1;
      tick;
      PIX_EN = 0;
   endtask

   task automatic vsync(input bit gaps);
      repeat (3) sample(1, 1, 0, 24'($urandom), gaps);
      repeat (4) sample(0, 1, 0, 24'($urandom), gaps);
      repeat (4) sample(1, 1, 0, 24'($urandom), gaps);
   endtask

   task automatic lines(input bit stall, input bit gaps);
      for (int y = 0; y < 4; y++) begin
         for (int x = 0; x < 8; x++) begin
            px[y*8+x] = 24'($urandom);
            sample(1, 1, 1, px[y*8+x], gaps);
         end
         for (int k = 0; k < 16; k++) begin
            if (stall && y == 1 && k == 8) MEM_READY = 1;
            sample(1, !(k >= 2 && k < 6), 0, 24'($urandom), gaps);
         end
      end
   endtask

   // pixels with index in [lo,hi) are expected to be lost to overflow
   task automatic add_frame(input int lo, input int hi);
      for (int i = 0; i < 32; i++)
         if (i < lo || i >= hi) begin
            exp.push_back({FB + 20'(i), pack(px[i])});
            if (i < 10) exp_c.push_back({FB_C + 20'(i), pack(px[i])});
         end
   endtask

   task automatic wait_done;
      int n;
      n = 0;
      ADDR = BASE + 4;
      #1;
      while (!(data_o[1] && data_o_c[1]) && n < 3000) begin
         tick;
         n++;
      end
      vectors++;
      if (!(data_o[1] && data_o_c[1])) begin
         miscompares++;
         $display("FAIL done_timeout: status=%h status_c=%h, required done bit set in both", data_o, data_o_c);
      end
   endtask

   task automatic clear_q;
      wq.delete();
      wq_c.delete();
      exp.delete();
      exp_c.delete();
   endtask

   task automatic test_reset;
      logic [31:0] d, dc;
      RESET = 1;
      repeat (3) tick;
      RESET = 0;
      tick;
      vectors++;
      if ({mem_wr, irq, mem_addr, mem_data} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: wr=%b irq=%b addr=%h data=%h, required all 0", mem_wr, irq, mem_addr, mem_data);
      end
      for (int r = 0; r < 5; r++) begin
         cpu_read(BASE + 32'(4*r), d, dc);
         vectors++;
         if (d !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_reg[%0d]: got %h required 0", 4*r, d);
         end
      end
      cpu_write(BASE + 32'h100, 32'h1);
      cpu_read(BASE + 4, d, dc);
      vectors++;
      if (d !== 32'd0) begin
         miscompares++;
         $display("FAIL outside_write: status %h required 0", d);
      end
      cpu_write(BASE, 32'h2);
      cpu_read(BASE, d, dc);
      vectors++;
      if (d !== 32'd2) begin
         miscompares++;
         $display("FAIL ctrl_readback: got %h required 2", d);
      end
      cpu_write(BASE, 32'h0);
   endtask

   task automatic test_pack_latency_abort;
      logic [31:0] d, dc;
      clear_q();
      MEM_READY = 0;
      cpu_write(BASE, 32'h1);
      vsync(0);
      cpu_read(BASE + 4, d, dc);
      vectors++;
      if (d !== 32'h1) begin
         miscompares++;
         $display("FAIL armed_status: got %h required 1", d);
      end
      {RED, GREEN, BLUE} = {8'hFF, 8'h00, 8'h80};
      VGA_BLANK_N = 1;
      PIX_EN = 1;
      tick;
      PIX_EN = 0;
      for (int c = 0; c < 3; c++) begin
         vectors++;
         if (mem_wr !== (c == 2)) begin
            miscompares++;
            $display("FAIL latency_wr[%0d]: got %b required %b", c, mem_wr, c == 2);
         end
         if (c < 2) tick;
      end
      vectors++;
      if ({mem_addr, mem_data} !== {FB, 16'h401F}) begin
         miscompares++;
         $display("FAIL pack: addr=%h data=%h required %h/401f", mem_addr, mem_data, FB);
      end
      repeat (4) sample(1, 1, 1, 24'($urandom), 0);
      repeat (3) tick;
      cpu_read(BASE + 4, d, dc);
      vectors++;
      if (d !== 32'h51) begin
         miscompares++;
         $display("FAIL level5_status: got %h required 51", d);
      end
      cpu_write(BASE, 32'h0);
      vectors++;
      if (mem_wr !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_wr: got %b required 0", mem_wr);
      end
      cpu_read(BASE + 4, d, dc);
      vectors++;
      if (d !== 32'h0) begin
         miscompares++;
         $display("FAIL abort_status: got %h required 0", d);
      end
      MEM_READY = 1;
      repeat (4) tick;
      vectors++;
      if (wq.size() !== 0) begin
         miscompares++;
         $display("FAIL abort_leak: %0d writes after abort, required 0", wq.size());
      end
   endtask

   task automatic check_writes(input logic [31:0] st, input logic [31:0] st_c);
      logic [31:0] d, dc;
      vectors++;
      if (wq.size() !== exp.size() || wq_c.size() !== exp_c.size()) begin
         miscompares++;
         $display("FAIL write_count: got %0d/%0d required %0d/%0d", wq.size(), wq_c.size(), exp.size(), exp_c.size());
      end
      foreach (exp[i]) begin
         vectors++;
         if (i >= wq.size() || wq[i] !== exp[i]) begin
            miscompares++;
            $display("FAIL write[%0d]: got %h required %h", i, i < wq.size() ? wq[i] : 36'hx, exp[i]);
         end
      end
      foreach (exp_c[i]) begin
         vectors++;
         if (i >= wq_c.size() || wq_c[i] !== exp_c[i]) begin
            miscompares++;
            $display("FAIL write_c[%0d]: got %h required %h", i, i < wq_c.size() ? wq_c[i] : 36'hx, exp_c[i]);
         end
      end
      cpu_read(BASE + 4, d, dc);
      vectors++;
      if (d !== st || dc !== st_c || irq !== st[1] || irq_c !== st_c[1]) begin
         miscompares++;
         $display("FAIL status: got %h/%h irq %b/%b required %h/%h", d, dc, irq, irq_c, st, st_c);
      end
      cpu_read(BASE + 8, d, dc);
      vectors++;
      if (d !== 32'd8 || dc !== 32'd8) begin
         miscompares++;
         $display("FAIL hcount: got %0d/%0d required 8", d, dc);
      end
      cpu_read(BASE + 12, d, dc);
      vectors++;
      if (d !== 32'd4 || dc !== 32'd4) begin
         miscompares++;
         $display("FAIL vcount: got %0d/%0d required 4", d, dc);
      end
   endtask

   task automatic test_frame;
      clear_q();
      MEM_READY = 1;
      cpu_write(BASE, 32'h1);
      vsync(1);
      lines(0, 1);
      add_frame(32, 32);
      vsync(1);
      wait_done();
      check_writes(32'h02, 32'h0A);
   endtask

   task automatic test_overflow;
      clear_q();
      MEM_READY = 0;
      cpu_write(BASE, 32'h1);
      vsync(1);
      lines(1, 1);
      add_frame(8, 16);
      vsync(1);
      wait_done();
      check_writes(32'h06, 32'h0E);
   endtask

   task automatic test_continuous;
      logic [31:0] d, dc;
      clear_q();
      MEM_READY = 1;
      cpu_write(BASE, 32'h3);
      vsync(1);
      lines(0, 1);
      add_frame(32, 32);
      vsync(1);
      lines(0, 1);
      cpu_read(BASE + 4, d, dc);
      vectors++;
      if (d !== 32'h03 || dc !== 32'h0B || irq !== 1'b1) begin
         miscompares++;
         $display("FAIL cont_done: got %h/%h irq %b required 03/0b irq 1", d, dc, irq);
      end
      cpu_write(BASE + 4, 32'h2);
      cpu_read(BASE + 4, d, dc);
      vectors++;
      if (d !== 32'h01 || dc !== 32'h09 || irq !== 1'b0) begin
         miscompares++;
         $display("FAIL w1c_done: got %h/%h irq %b required 01/09 irq 0", d, dc, irq);
      end
      vsync(1);
      lines(0, 1);
      add_frame(32, 32);
      vsync(1);
      wait_done();
      check_writes(32'h03, 32'h0B);
      cpu_write(BASE, 32'h0);
   endtask

   task automatic test_reset_mid;
      logic [31:0] d, dc;
      MEM_READY = 0;
      cpu_write(BASE, 32'h1);
      vsync(0);
      repeat (4) sample(1, 1, 1, 24'($urandom), 0);
      repeat (3) tick;
      vectors++;
      if (mem_wr !== 1'b1) begin
         miscompares++;
         $display("FAIL pre_reset_wr: got %b required 1", mem_wr);
      end
      RESET = 1;
      tick;
      vectors++;
      if ({mem_wr, irq, mem_addr, mem_data} !== '0) begin
         miscompares++;
         $display("FAIL mid_reset_outputs: wr=%b irq=%b addr=%h data=%h required 0", mem_wr, irq, mem_addr, mem_data);
      end
      RESET = 0;
      MEM_READY = 1;
      tick;
      for (int r = 0; r < 4; r++) begin
         cpu_read(BASE + 32'(4*r), d, dc);
         vectors++;
         if (d !== 32'd0 || dc !== 32'd0) begin
            miscompares++;
            $display("FAIL mid_reset_reg[%0d]: got %h/%h required 0", 4*r, d, dc);
         end
      end
   endtask

   initial begin
      test_reset();
      test_pack_latency_abort();
      test_frame();
      test_overflow();
      test_continuous();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
